// File: rtl/tdm_frame_tx_if.sv
// Write-port bundle for tdm_frame_tx: sample writes into the fill bank plus the
// commit pulse that hands the fill bank over for serialisation.
interface tdm_frame_tx_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_ch;
  logic [7:0] wr_data;
  logic       wr_commit;

  // Producer side: the block filling frames
  modport master (
    output wr_valid,
    output wr_ch,
    output wr_data,
    output wr_commit,
    input  wr_ready
  );

  // Consumer side: tdm_frame_tx
  modport slave (
    input  wr_valid,
    input  wr_ch,
    input  wr_data,
    input  wr_commit,
    output wr_ready
  );
endinterface

// File: rtl/tdm_frame_tx.sv
// tdm_frame_tx: double-buffered 32-channel frame store serialised as a continuous
// TDM bit stream, channel 0..31, MSb first, with a one-slot frame sync on ch0 bit7.
// Launches on posedge serial_clk; the downstream receiver samples on the inverted clock.
//
// Build option: define TDM_IDLE_CODE_EN to give each bank per-channel written flags,
// so channels not written before a commit serialise IDLE_BYTE instead of old contents.
module tdm_frame_tx #(
  parameter int unsigned NUM_CH    = 32,
  parameter logic [7:0]  IDLE_BYTE = 8'hFF
) (
  input  logic          serial_clk,
  input  logic          reset,
  input  logic          enable,
  tdm_frame_tx_if.slave wr,
  output logic          data_out,
  output logic          frame_sync,
  output logic [4:0]    cur_ch,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  localparam logic [4:0] LastCh = 5'(NUM_CH - 1);

  state_e      state_q;
  logic [2:0]  bit_cnt_q;
  logic [4:0]  ch_cnt_q;
  logic        play_sel_q;
  logic        commit_pending_q;
  logic [7:0]  bank_q [2][NUM_CH];

`ifdef TDM_IDLE_CODE_EN
  logic [NUM_CH-1:0] written_q [2];
`endif

  logic       issue;
  logic       frame_start;
  logic       swap;
  logic       last_slot;
  logic       play_bank;
  logic       fill_sel;
  logic       wr_en;
  logic [7:0] play_byte;

  // Slot issue, swap and write qualification decoded from current state
  always_comb begin
    // IDLE issues ch0 bit7 in the same edge that first samples enable high
    issue       = (state_q != StIdle) || enable;
    frame_start = issue && (ch_cnt_q == 5'd0) && (bit_cnt_q == 3'd7);
    swap        = frame_start && commit_pending_q;
    last_slot   = (ch_cnt_q == LastCh) && (bit_cnt_q == 3'd0);
    // On a swap the incoming bank already supplies this first bit
    play_bank   = swap ? ~play_sel_q : play_sel_q;
    fill_sel    = ~play_sel_q;
    wr_en       = wr.wr_valid && wr.wr_ready;
  end

  // Byte for the slot being issued, substituted by the idle code if never written
  always_comb begin
    play_byte = bank_q[play_bank][ch_cnt_q];
`ifdef TDM_IDLE_CODE_EN
    if (!written_q[play_bank][ch_cnt_q]) begin
      play_byte = IDLE_BYTE;
    end
`endif
  end

  assign wr.wr_ready = ~commit_pending_q;

  // Frame store: writes only ever land in the fill bank
  always_ff @(posedge serial_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        bank_q[0][i] <= 8'h00;
        bank_q[1][i] <= 8'h00;
      end
    end else if (wr_en) begin
      bank_q[fill_sel][wr.wr_ch] <= wr.wr_data;
    end
  end

`ifdef TDM_IDLE_CODE_EN
  // Written flags travel with their bank; the bank becoming fill starts clean.
  // A write and a swap never coincide since swap needs commit_pending=1.
  always_ff @(posedge serial_clk or posedge reset) begin
    if (reset) begin
      written_q[0] <= '0;
      written_q[1] <= '0;
    end else if (swap) begin
      written_q[play_sel_q] <= '0;
    end else if (wr_en) begin
      written_q[fill_sel][wr.wr_ch] <= 1'b1;
    end
  end
`endif

  // Sequencer: state, slot counters, bank select, commit flag and registered outputs
  always_ff @(posedge serial_clk or posedge reset) begin
    if (reset) begin
      state_q          <= StIdle;
      bit_cnt_q        <= 3'd7;
      ch_cnt_q         <= 5'd0;
      play_sel_q       <= 1'b0;
      commit_pending_q <= 1'b0;
      data_out         <= IDLE_BYTE[7];
      frame_sync       <= 1'b0;
      cur_ch           <= 5'd0;
      busy             <= 1'b0;
    end else begin
      // A commit while one is pending is absorbed; the swap wins over a new commit
      if (swap) begin
        play_sel_q       <= ~play_sel_q;
        commit_pending_q <= 1'b0;
      end else if (wr.wr_commit) begin
        commit_pending_q <= 1'b1;
      end

      if (issue) begin
        data_out   <= play_byte[bit_cnt_q];
        frame_sync <= frame_start;
        cur_ch     <= ch_cnt_q;
        busy       <= 1'b1;
        bit_cnt_q  <= bit_cnt_q - 3'd1;
        if (bit_cnt_q == 3'd0) begin
          ch_cnt_q <= (ch_cnt_q == LastCh) ? 5'd0 : ch_cnt_q + 5'd1;
        end
        // Frames are never cut short: without enable the frame drains to its end
        if (last_slot) begin
          state_q <= enable ? StRun : StIdle;
        end else begin
          state_q <= enable ? StRun : StDrain;
        end
      end else begin
        state_q    <= StIdle;
        data_out   <= IDLE_BYTE[7];
        frame_sync <= 1'b0;
        cur_ch     <= 5'd0;
        busy       <= 1'b0;
      end
    end
  end

endmodule

// File: doc/tdm_frame_tx.md
Name: tdm_frame_tx

Overview:
- Upstream stage of the TDM receive path.
- Takes 8-bit channel samples from a parallel write port into a double-buffered 32-channel frame store.
- Emits them as a continuous serial TDM stream with a one-bit frame sync: channels 0-31, MSb first.
- data_out/frame_sync connect directly to the TDMI data_in/frame_sync inputs. Both blocks share serial_clk. This block launches on posedge; TDMI samples on the inverted clock.

Parameters:
- NUM_CH, 32, channels per frame; fixed at 32 because channel index width is 5.
- IDLE_BYTE, 8'hFF, value driven on data_out while in IDLE (see Behaviour).

Ports:
- serial_clk  input  1  serial bit clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  start/continue streaming; level, sampled on posedge.
- wr_valid  input  1  write request for the fill bank.
- wr_ready  output  1  fill bank accepts writes.
- wr_ch  input  5  channel index of write.
- wr_data  input  8  sample byte.
- wr_commit  input  1  one-cycle pulse: fill bank complete, swap at next frame boundary.
- data_out  output  1  serial TDM data, registered.
- frame_sync  output  1  high for exactly the bit-7 slot of channel 0, registered.
- cur_ch  output  5  channel currently on data_out.
- busy  output  1  high in RUN and DRAIN.

Behaviour:
- Decided: reset reset, asynchronous, active-high; clock serial_clk.
- Reset values:
  - data_out=1 (bit 7 of IDLE_BYTE), frame_sync=0, cur_ch=0, busy=0, wr_ready=1.
  - Both banks cleared to 8'h00; commit_pending=0; active bank=0.
  - FSM=IDLE, bit_cnt=7, ch_cnt=0.
- Banks: fill bank (written) and play bank (serialised).
  - A write occurs when wr_valid&wr_ready: fill[wr_ch]<=wr_data.
- Commit:
  - wr_commit sets commit_pending; wr_ready=~commit_pending.
  - A wr_valid&wr_ready in the same cycle as wr_commit is written and included in the committed bank.
  - wr_commit while commit_pending already set is ignored.
- Swap: when the FSM issues bit 7 of channel 0 (every frame start) and commit_pending=1:
  - Banks exchange and commit_pending clears.
  - The new play bank is serialised starting with that same bit.
  - wr_ready returns high the following cycle.
- FSM states:
  - IDLE: data_out shows IDLE_BYTE[7] constant; frame_sync=0, busy=0. enable=1 -> RUN. On the first RUN cycle the outputs are ch0 bit7 with frame_sync=1.
  - RUN: each posedge outputs data_out<=play[ch_cnt][bit_cnt] and cur_ch<=ch_cnt; frame_sync<=(ch_cnt==0 && bit_cnt==7).
    - bit_cnt decrements 7->0 with wrap.
    - On bit_cnt==0, ch_cnt increments and wraps 31->0. Frame length is 256 cycles.
    - Last slot = ch31 bit0. If enable=0 at that slot -> IDLE; else the frame restarts with frame_sync.
    - enable falling mid-frame -> DRAIN.
  - DRAIN: identical to RUN; completes the current frame, then enters IDLE after ch31 bit0. enable re-asserted during DRAIN returns to RUN with no gap.
- Latency: the first serial bit appears 1 cycle after enable is first sampled high in IDLE.
- Ordering: a write to the play bank is impossible. Data written before commit appears starting at the first frame boundary after the commit cycle, at the earliest 1 cycle after the commit.
- Commit in IDLE: commit_pending swaps on the first frame start.
- Reset mid-frame: everything returns immediately to reset values; no partial frame completion.

Optional Feature:
- Macro TDM_IDLE_CODE_EN.
- Defined:
  - Each fill-bank channel carries a written flag, cleared on swap for the new fill bank.
  - Channels never written before a commit serialise IDLE_BYTE instead of stale/zero data.
- Undefined:
  - No flags; unwritten channels retain whatever the bank last held (00 after reset).

Test Plan:
- Reset, write ch0=A5, ch31=3C, commit, enable=1:
  - First frame: frame_sync high 1 cycle with data_out bits 1,0,1,0,0,1,0,1.
  - Last 8 bits: 0,0,1,1,1,1,0,0.
  - Period between frame_sync pulses = 256 cycles.
- Streaming, commit new bank (ch5=81) mid-frame:
  - Current frame ch5 keeps old value.
  - Next frame ch5 = 1,0,0,0,0,0,0,1.
  - wr_ready low from the commit cycle until 1 cycle after the swap.
- enable dropped at ch10:
  - Frame completes through ch31 bit0; busy falls.
  - Then no frame_sync; data_out constant 1.
- Assert reset at ch17 bit3:
  - Outputs return to reset values asynchronously; banks read 00 after re-enable without new writes.
- Back-to-back wr_commit plus write in the same cycle as a second commit while pending: second commit ignored, write rejected (wr_ready=0).
- TDM_IDLE_CODE_EN defined, commit with only ch2=12 written: ch2 emits 12, all other channels emit FF; undefined build emits 00.
